// File: rtl/hp0_bias_weight_receiver.sv
// hp0_bias_weight_receiver: receive side of the HP0 bias/weight fetch.
// Bias beats are written to the bias BRAM; weight beats pass through a one-word output register.
module hp0_bias_weight_receiver #(
  parameter int DATA_W  = 64,
  parameter int BIAS_AW = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hp_0_ap_start,
  input  logic               is_bias,
  input  logic [31:0]        bias_transferbyte,
  input  logic [31:0]        weight_transferbyte,
  input  logic [DATA_W-1:0]  s_axis_tdata,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  input  logic               s_axis_tlast,
  output logic               bias_bram_we,
  output logic [BIAS_AW-1:0] bias_bram_addr,
  output logic [DATA_W-1:0]  bias_bram_wdata,
  output logic               bias_bram_full,
  output logic [DATA_W-1:0]  weight_tdata,
  output logic               weight_tvalid,
  input  logic               weight_tready,
  output logic               weight_done,
  output logic               err
);

  localparam logic [31:0]        BYTES_PER_WORD = 32'(DATA_W / 8);
  localparam logic [31:0]        BRAM_DEPTH     = 32'd1 << BIAS_AW;
  localparam logic [BIAS_AW-1:0] ADDR_ONE       = {{(BIAS_AW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BIAS   = 2'd1,
    WEIGHT = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  function automatic logic [31:0] words_of(input logic [31:0] bytes);
    logic [31:0] rem;
    rem      = bytes % BYTES_PER_WORD;
    words_of = (bytes / BYTES_PER_WORD) + ((rem != 32'd0) ? 32'd1 : 32'd0);
  endfunction

  state_t             state_r;
  state_t             state_nxt_s;
  logic               start_d_r;
  logic               pend_r;
  logic               pend_bias_r;
  logic [31:0]        pend_bytes_r;
  logic [31:0]        cnt_r;
  logic [31:0]        target_r;
  logic [BIAS_AW-1:0] wr_ptr_r;

  logic               rise_s;
  logic               fall_s;
  logic               go_s;
  logic               go_bias_s;
  logic [31:0]        go_bytes_s;
  logic [31:0]        go_target_s;
  logic               go_zero_s;
  logic               room_s;
  logic               last_s;
  logic               accept_s;
  logic               handoff_s;
  logic               abort_s;

  assign rise_s      = hp_0_ap_start & ~start_d_r;
  assign fall_s      = ~hp_0_ap_start & start_d_r;
  // A start seen while busy is held in pend_r and taken once back in IDLE.
  assign go_s        = (state_r == IDLE) && hp_0_ap_start && (rise_s || pend_r);
  assign go_bias_s   = rise_s ? is_bias : pend_bias_r;
  assign go_bytes_s  = rise_s ? (is_bias ? bias_transferbyte : weight_transferbyte) : pend_bytes_r;
  assign go_target_s = words_of(go_bytes_s);
  assign go_zero_s   = (go_target_s == 32'd0);
  assign room_s      = (cnt_r < target_r);
  assign last_s      = (cnt_r == (target_r - 32'd1));
  assign accept_s    = s_axis_tvalid && s_axis_tready;
  assign handoff_s   = weight_tvalid && weight_tready;
  assign abort_s     = fall_s && (state_r != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a falling start level aborts any active phase.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (go_s && !go_zero_s) begin
          state_nxt_s = go_bias_s ? BIAS : WEIGHT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BIAS: begin
        if (fall_s || (accept_s && last_s)) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = BIAS;
        end
      end
      WEIGHT: begin
        if (fall_s) begin
          state_nxt_s = IDLE;
        end else if (accept_s && last_s) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = WEIGHT;
        end
      end
      DRAIN: begin
        if (fall_s || handoff_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Stream ready; gated by the start level so no beat is taken in an aborting cycle.
  always_comb begin
    s_axis_tready = 1'b0;
    case (state_r)
      BIAS:    s_axis_tready = room_s && hp_0_ap_start;
      WEIGHT:  s_axis_tready = room_s && hp_0_ap_start && (!weight_tvalid || weight_tready);
      default: s_axis_tready = 1'b0;
    endcase
  end

  // Phase bookkeeping, bias BRAM write port and error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_d_r       <= 1'b0;
      pend_r          <= 1'b0;
      pend_bias_r     <= 1'b0;
      pend_bytes_r    <= 32'd0;
      cnt_r           <= 32'd0;
      target_r        <= 32'd0;
      wr_ptr_r        <= '0;
      bias_bram_we    <= 1'b0;
      bias_bram_addr  <= '0;
      bias_bram_wdata <= '0;
      bias_bram_full  <= 1'b0;
      err             <= 1'b0;
    end else begin
      start_d_r    <= hp_0_ap_start;
      bias_bram_we <= 1'b0;
      if (go_s) begin
        pend_r   <= 1'b0;
        cnt_r    <= 32'd0;
        target_r <= go_target_s;
        if (go_bias_s) begin
          wr_ptr_r       <= '0;
          bias_bram_addr <= '0;
          bias_bram_full <= go_zero_s;
          if (go_target_s > BRAM_DEPTH) begin
            err <= 1'b1;
          end
        end
      end else if (fall_s) begin
        pend_r <= 1'b0;
      end else if (rise_s) begin
        pend_r       <= 1'b1;
        pend_bias_r  <= is_bias;
        pend_bytes_r <= is_bias ? bias_transferbyte : weight_transferbyte;
      end
      if (accept_s) begin
        cnt_r <= cnt_r + 32'd1;
        if (s_axis_tlast != last_s) begin
          err <= 1'b1;
        end
        if (state_r == BIAS) begin
          bias_bram_we    <= 1'b1;
          bias_bram_addr  <= wr_ptr_r;
          bias_bram_wdata <= s_axis_tdata;
          wr_ptr_r        <= wr_ptr_r + ADDR_ONE;
          if (last_s) begin
            bias_bram_full <= 1'b1;
          end
        end
      end
      if (abort_s) begin
        err <= 1'b1;
      end
    end
  end

  // Weight output register and completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      weight_tvalid <= 1'b0;
      weight_tdata  <= '0;
      weight_done   <= 1'b0;
    end else begin
      weight_done <= 1'b0;
      if (abort_s) begin
        weight_tvalid <= 1'b0;
      end else if (accept_s && (state_r == WEIGHT)) begin
        weight_tvalid <= 1'b1;
        weight_tdata  <= s_axis_tdata;
      end else if (weight_tready) begin
        weight_tvalid <= 1'b0;
      end
      if (go_s && !go_bias_s && go_zero_s) begin
        weight_done <= 1'b1;
      end else if ((state_r == DRAIN) && handoff_s && !fall_s) begin
        weight_done <= 1'b1;
      end
    end
  end

endmodule

// File: doc/hp0_bias_weight_receiver.md
# hp0_bias_weight_receiver

Receive side of the HP0 bias/weight fetch. Consumes the 64-bit read-data stream that the DMA returns after the fetch controller raises `hp_0_ap_start`. Bias words are written into the bias BRAM and `bias_bram_full` is raised when the programmed byte count has landed. Weight words are forwarded through a registered skid stage to the weight buffer, and a done pulse is generated when the final weight word has been delivered.

## Interface
- `DATA_W`, 64: stream and BRAM data width; byte counts are converted to words with `DATA_W/8` bytes per word.
- `BIAS_AW`, 10: bias BRAM address width.
- `clk` in 1: single clock for all logic.
- `rst` in 1: synchronous, active-high reset.
- `hp_0_ap_start` in 1: fetch request level from the controller; a rising edge starts a phase.
- `is_bias` in 1: high means the current phase is a bias load; sampled on the `hp_0_ap_start` rising edge.
- `bias_transferbyte` in 32: bias byte count, latched at phase start.
- `weight_transferbyte` in 32: weight byte count, latched at phase start.
- `s_axis_tdata` in DATA_W: read data from the HP0 stream.
- `s_axis_tvalid` in 1: read data valid.
- `s_axis_tready` out 1: read data accepted.
- `s_axis_tlast` in 1: DMA end-of-transfer marker; checked only, never used to terminate a phase.
- `bias_bram_we` out 1: bias BRAM write enable.
- `bias_bram_addr` out BIAS_AW: bias BRAM write address.
- `bias_bram_wdata` out DATA_W: bias BRAM write data.
- `bias_bram_full` out 1: bias load complete; level signal.
- `weight_tdata` out DATA_W: weight data to the weight buffer.
- `weight_tvalid` out 1: weight data valid.
- `weight_tready` in 1: weight buffer ready.
- `weight_done` out 1: one-cycle pulse after the last weight word is delivered.
- `err` out 1: sticky protocol error flag.

## Operation
- States: IDLE, BIAS, WEIGHT, DRAIN.
- Word count: `target = ceil(bytes / (DATA_W/8))`, 32-bit arithmetic. The count is latched from `bias_transferbyte` or `weight_transferbyte` on the `hp_0_ap_start` rising edge. A word counter `cnt` is cleared at the same edge.
- Leaving IDLE on a `hp_0_ap_start` rising edge:
  - `is_bias`=1 goes to BIAS. `bias_bram_full` is cleared and `bias_bram_addr` is reset to 0.
  - `is_bias`=0 goes to WEIGHT.
- BIAS:
  - `s_axis_tready` = (`cnt` < `target`).
  - Each accepted beat produces one registered BRAM write and increments the address.
  - On the final beat, set `bias_bram_full`. It stays high until the next bias phase start or `rst`.
  - Then return to IDLE.
- WEIGHT:
  - `s_axis_tready` = (`cnt` < `target`) && (output slot empty || `weight_tready`).
  - The single output register holds one word.
  - After the final input beat, go to DRAIN.
- DRAIN:
  - Wait for the output register to hand off.
  - Pulse `weight_done`, then go to IDLE.
- Zero target: BIAS sets `bias_bram_full` the next cycle; WEIGHT pulses `weight_done` the next cycle. No beats are accepted in either case.
- `s_axis_tready` is 0 in IDLE, in DRAIN, and whenever `cnt` == `target`. Excess beats are back-pressured and never dropped silently.
- `err` is set (sticky until `rst`) on any of:
  - `s_axis_tlast` high on a beat that is not the final beat;
  - final beat accepted with `s_axis_tlast` low;
  - `hp_0_ap_start` falling while in BIAS, WEIGHT, or DRAIN.
- Abort on a `hp_0_ap_start` falling edge mid-phase: go to IDLE and clear `weight_tvalid`. `bias_bram_full` is not set and `weight_done` is not pulsed.
- BRAM address increments modulo 2^BIAS_AW. A `target` greater than 2^BIAS_AW wraps and sets `err`.

## Timing
- Reset values: state IDLE, `s_axis_tready`=0, `bias_bram_we`=0, `bias_bram_addr`=0, `bias_bram_wdata`=0, `bias_bram_full`=0, `weight_tvalid`=0, `weight_tdata`=0, `weight_done`=0, `err`=0, `cnt`=0.
- Phase start: the rising edge is detected at cycle T. `s_axis_tready` can first be high at T+1.
- Bias write: a beat accepted at cycle N produces `bias_bram_we`=1 at N+1, with the address and data of that beat.
- `bias_bram_full`: rises at N+1, where N is the cycle the final bias beat is accepted, coincident with the last write.
- Weight path: a beat accepted at N gives `weight_tvalid`=1 at N+1. The output holds while `weight_tready` is low.
- Weight throughput: one word per cycle while `weight_tready` stays high.
- `weight_done`: high exactly one cycle, the cycle after the final weight handshake.
- Simultaneous events: a rising edge of `hp_0_ap_start` in the same cycle as a DRAIN completion is honoured after the `weight_done` cycle. It is never lost; it is held as a pending start.
- `rst` mid-phase returns all outputs to their reset values on the next edge.

## Test plan
- Bias load, 64 bytes (8 words), continuous `s_axis_tvalid`, `tlast` on beat 8:
  - addresses 0..7 written in 8 consecutive cycles;
  - `bias_bram_full` rises with the write to address 7;
  - `err`=0.
- Weight load, 40 bytes (5 words), with `weight_tready` toggling 1,0,1,0:
  - all 5 words delivered in order with no duplicates;
  - `weight_done` is a single pulse one cycle after the 5th handshake.
- Non-multiple byte count, bias 20 bytes: target is 3 words; `bias_bram_full` after 3 writes; a 4th offered beat sees `s_axis_tready`=0.
- Zero-byte weight phase: `weight_done` pulses at T+1; no beats are accepted.
- Early `tlast` on beat 2 of 4: `err` goes to 1 and stays 1. Loading continues to 4 words; `bias_bram_full` still rises.
- Abort and reset:
  - drop `hp_0_ap_start` after 3 of 8 weight words: return to IDLE, `err`=1, no `weight_done`;
  - assert `rst` mid-bias: all outputs return to their reset values on the next cycle.
